i2s_xmtr: RTL and testbench
===========================

# i2s_xmtr

I2S transmitter: accepts parallel left/right sample pairs over a valid/ready handshake, generates the serial bit clock (sck) and word select (ws) as bus master, and shifts each sample out MSB-first on sd. It is the transmit-side counterpart to the I2S receive path (edge detector, input controller, shift register). It drives an external codec or the receive path in loopback tests.

## Interface
- DATA_WIDTH, 16: bits per channel sample; must be ≥ 2.
- CLK_DIV, 2: clk cycles per sck half-period; must be ≥ 1. One bit slot = 2*CLK_DIV clk cycles.
- clk  input  1  system clock; all state is on its rising edge.
- n_rst  input  1  asynchronous active-low reset.
- enable  input  1  run request; sampled only at frame boundaries.
- sample_left  input  DATA_WIDTH  left-channel sample.
- sample_right  input  DATA_WIDTH  right-channel sample.
- sample_valid  input  1  the sample pair is valid.
- sample_ready  output  1  the holding register is empty and can accept a pair.
- sck  output  1  I2S bit clock, registered.
- ws  output  1  word select (0 = left, 1 = right), registered.
- sd  output  1  serial data, registered.
- underrun  output  1  one-clk pulse when a frame starts with no sample pair available.
- busy  output  1  high while in RUN or STOPPING.

## Operation
- Holding register: captures {left, right} when sample_valid && sample_ready. holding_full sets on capture and clears when the pair is loaded into the shift register. sample_ready = !holding_full, registered.
- Frame: 2*DATA_WIDTH bit slots, numbered k = 0..2W-1.
  - Left word is in slots 0..W-1; right word is in slots W..2W-1. MSB goes first.
  - ws in slot k = ((k+1) mod 2W) ≥ W. ws therefore leads each word by one slot (standard I2S).
- Frame load at slot 0:
  - If holding is full, the 2W-bit shift register is loaded with {left, right}.
  - If holding is empty but a handshake fires in this same cycle, the incoming pair bypasses the holding register and loads directly. No underrun occurs in this case.
  - Otherwise the shift register is loaded with zeros and underrun pulses for one clk.
- FSM:
  - IDLE → RUN when enable && (holding_full || handshake). The frame load happens in the transition cycle.
  - RUN → STOPPING when enable = 0 is sampled in any cycle.
  - STOPPING → RUN at the end of slot 2W-1 if enable is high again. Otherwise STOPPING → IDLE.
  - RUN at the end of slot 2W-1 with enable high: the next frame is loaded, wrapping k to 0.
  - STOPPING always completes the current frame, so a partial word is never emitted.
- In IDLE: sck = 0, ws = 0, sd = 0, busy = 0. The holding register still accepts one pair.

## Timing
- Reset values: sck 0, ws 0, sd 0, sample_ready 1, underrun 0, busy 0, holding empty, state IDLE, all counters 0.
- Counters:
  - div_cnt runs 0..CLK_DIV-1. sck toggles when div_cnt = CLK_DIV-1.
  - bit_cnt runs 0..2W-1 and advances on each sck 1→0 transition.
- sd and ws update in the same clk as the sck falling edge. The receiver samples on the sck rising edge, CLK_DIV clk cycles later.
- IDLE→RUN cycle: the next clk shows sck = 0, ws = 0, and sd = bit W-1 of left. sck first rises CLK_DIV cycles later.
- Reload latency:
  - sample_ready returns high 1 clk after the load cycle.
  - A new pair must be handshaken before the next slot-0 load (within 2W*2*CLK_DIV clk) to avoid underrun.
- Simultaneous events:
  - Handshake in the load cycle with holding full: the holding content is loaded, the new pair is captured, and holding stays full.
  - enable deassert and the frame boundary in the same clk: go to IDLE, with no load and no underrun.
- Asynchronous reset mid-frame: all outputs return to their reset values immediately. A pending holding pair is discarded.

## Test plan
All scenarios use W=16, CLK_DIV=2, so one frame is 128 clk cycles.
- Single pair, L=0xA5C3, R=0x0F01, enable=1 → sd sampled on the 32 sck rises = 1010010111000011 then 0000111100000001. ws=1 for slots 15..30 and 0 elsewhere. underrun stays 0.
- No second pair supplied, enable held → frame 2 sd is all zeros. underrun pulses exactly once, in the frame-2 load cycle, 128 clk after the first load.
- Back-to-back pairs, each handshaken as soon as sample_ready rises → continuous sck and no underrun over 4 frames. sd matches each pair in order.
- Handshake arrives in the load cycle with holding empty (bypass) → the pair transmits in that frame, underrun=0, sample_ready stays 1.
- enable dropped at slot 5 → the frame completes all 32 slots, then busy falls, and sck/ws/sd hold 0 with no extra sck edges.
- n_rst asserted at slot 20 → sck/ws/sd/underrun/busy go to 0 and sample_ready goes to 1 without waiting for clk. After release, a new pair starts a clean frame at slot 0.

Source files
------------

// File: rtl/i2s_xmtr_if.sv
// Sample-pair handshake bundle between a sample producer and the I2S transmitter.
// Ports: sample_left/sample_right (pair data), sample_valid (pair offered), sample_ready (holding slot free).
// master = producer side, slave = transmitter side.
interface i2s_xmtr_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] sample_left;
  logic [DATA_WIDTH-1:0] sample_right;
  logic                  sample_valid;
  logic                  sample_ready;

  modport master (
    output sample_left,
    output sample_right,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_left,
    input  sample_right,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/i2s_xmtr.sv
// I2S transmitter: serialises left/right sample pairs MSB-first as bus master (sck, ws, sd).
// Latency: pair visible on sd the clk after its frame load; one frame = 2*DATA_WIDTH*2*CLK_DIV clk.
// Backpressure: one-deep holding register; sample_ready low while it holds a pair not yet loaded.
// Ports: clk, n_rst (async active-low), enable (run request), smp (slave handshake),
//        sck/ws/sd (registered I2S outputs), underrun (1-clk pulse on empty frame), busy (RUN or STOPPING).
module i2s_xmtr #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       enable,
  i2s_xmtr_if.slave  smp,
  output logic       sck,
  output logic       ws,
  output logic       sd,
  output logic       underrun,
  output logic       busy
);

  localparam int FW = 2 * DATA_WIDTH;
  localparam int BW = $clog2(FW);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);
  localparam logic [BW-1:0] WS_FIRST = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [FW-1:0]   shift_q, shift_d;
  logic [FW-1:0]   hold_q, hold_d;
  logic            ready_q, ready_d;
  logic            sck_q, sck_d;
  logic            ws_q, ws_d;
  logic            underrun_q, underrun_d;

  logic            hs;
  logic            fall;
  logic            boundary;
  logic            load;
  logic            bypass;

  assign hs       = smp.sample_valid & ready_q;
  // sck 1->0 happens on the last divider tick of the high phase; that ends a bit slot.
  assign fall     = (state_q != S_IDLE) & sck_q & (div_q == DIV_LAST);
  assign boundary = fall & (bit_q == BIT_LAST);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    ready_d    = ready_q;
    sck_d      = sck_q;
    ws_d       = ws_q;
    underrun_d = 1'b0;
    load       = 1'b0;
    bypass     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable && (!ready_q || hs)) begin
          state_d = S_RUN;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        if (boundary) begin
          if (enable) load = 1'b1;
          else        state_d = S_IDLE;
        end else if (!enable) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (boundary) begin
          if (enable) begin
            state_d = S_RUN;
            load    = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      if (div_q == DIV_LAST) sck_d = ~sck_q;
      if (fall) begin
        bit_d   = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
        shift_d = {shift_q[FW-2:0], 1'b0};
        // ws leads each word by one slot: high for slots W-1 .. 2W-2.
        ws_d    = (bit_d >= WS_FIRST) && (bit_d != BIT_LAST);
      end
    end

    // An empty holding register with a same-cycle handshake feeds the shifter directly.
    bypass = load & ready_q & hs;

    if (load) begin
      div_d      = '0;
      bit_d      = '0;
      sck_d      = 1'b0;
      ws_d       = 1'b0;
      underrun_d = ready_q & ~hs;
      if (!ready_q)    shift_d = hold_q;
      else if (hs)     shift_d = {smp.sample_left, smp.sample_right};
      else             shift_d = '0;
    end

    if (state_d == S_IDLE) begin
      div_d   = '0;
      bit_d   = '0;
      sck_d   = 1'b0;
      ws_d    = 1'b0;
      shift_d = '0;
    end

    if (hs && !bypass) begin
      hold_d  = {smp.sample_left, smp.sample_right};
      ready_d = 1'b0;
    end else if (load && !ready_q) begin
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      ready_q    <= 1'b1;
      sck_q      <= 1'b0;
      ws_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      ready_q    <= ready_d;
      sck_q      <= sck_d;
      ws_q       <= ws_d;
      underrun_q <= underrun_d;
    end
  end

  assign smp.sample_ready = ready_q;
  assign sck              = sck_q;
  assign ws               = ws_q;
  assign sd               = shift_q[FW-1];
  assign underrun         = underrun_q;
  assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2s_xmtr.sv
// Scoreboard bench for i2s_xmtr (W=16, CLK_DIV=2): expected slots are queued on acceptance,
// a monitor pops and compares {ws, sd} on every sck rise.
module tb_i2s_xmtr;
  localparam int W  = 16;
  localparam int CD = 2;

  logic clk, n_rst, enable;
  logic sck, ws, sd, underrun, busy;

  i2s_xmtr_if #(.DATA_WIDTH(W)) smp_if ();

  i2s_xmtr #(.DATA_WIDTH(W), .CLK_DIV(CD)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .enable   (enable),
    .smp      (smp_if.slave),
    .sck      (sck),
    .ws       (ws),
    .sd       (sd),
    .underrun (underrun),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] exp_q[$];
  int rise_cnt = 0, first_rise = 0, last_rise = 0, slot_idx = 0;
  int ur_count = 0, ur_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
  endtask

  // Reference model: one frame of 2W slots, left word then right word, MSB first;
  // ws in slot k is high when (k+1) mod 2W falls in the right-word half.
  task automatic push_frame(input logic [W-1:0] l, input logic [W-1:0] r);
    for (int k = 0; k < 2*W; k++) begin
      logic sdv, wsv;
      sdv = (k < W) ? l[W-1-k] : r[2*W-1-k];
      wsv = (((k + 1) % (2*W)) >= W);
      exp_q.push_back({wsv, sdv});
    end
  endtask

  // Monitor: receiver-style sampling on each sck rise.
  initial begin
    logic prev_sck;
    logic [1:0] e;
    prev_sck = 1'b0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        prev_sck = 1'b0;
      end else begin
        if (sck && !prev_sck) begin
          if (rise_cnt == 0) first_rise = cyc;
          last_rise = cyc;
          rise_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_sck_rise", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("slot%0d_ws_sd", slot_idx % (2*W)), {30'd0, ws, sd}, {30'd0, e});
          end
          slot_idx++;
        end
        prev_sck = sck;
        if (underrun) begin
          ur_count++;
          ur_cyc = cyc;
        end
      end
    end
  end

  // Offer a pair and wait for acceptance; c is the cycle number of the accepting edge.
  task automatic send_pair(input logic [W-1:0] l, input logic [W-1:0] r, output int c);
    int n;
    n = 0;
    c = -1;
    @(negedge clk);
    smp_if.sample_left  = l;
    smp_if.sample_right = r;
    smp_if.sample_valid = 1'b1;
    while (!smp_if.sample_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (smp_if.sample_ready) begin
      c = cyc + 1;
      push_frame(l, r);
    end else begin
      chk("accept_timeout", 0, 1);
    end
    @(negedge clk);
    smp_if.sample_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_busy_fall"}, {31'd0, busy}, 0);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!smp_if.sample_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_ready_rise"}, {31'd0, smp_if.sample_ready}, 1);
  endtask

  task automatic idle_outputs(input string name);
    chk({name, "_sck"}, {31'd0, sck}, 0);
    chk({name, "_ws"},  {31'd0, ws},  0);
    chk({name, "_sd"},  {31'd0, sd},  0);
    chk({name, "_exp_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int c, ur0, n;
    logic [W-1:0] l, r;
    n_rst = 1'b0;
    enable = 1'b0;
    smp_if.sample_left  = '0;
    smp_if.sample_right = '0;
    smp_if.sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sck", {31'd0, sck}, 0);
    chk("rst_ws", {31'd0, ws}, 0);
    chk("rst_sd", {31'd0, sd}, 0);
    chk("rst_underrun", {31'd0, underrun}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", {31'd0, smp_if.sample_ready}, 1);
    n_rst = 1'b1;
    @(negedge clk);

    // Single fixed pair, then a starved second frame.
    enable = 1'b1;
    send_pair(16'hA5C3, 16'h0F01, c);
    chk("start_busy", {31'd0, busy}, 1);
    chk("start_sck", {31'd0, sck}, 0);
    chk("start_ws", {31'd0, ws}, 0);
    chk("start_sd_msb", {31'd0, sd}, 1);
    chk("start_ready", {31'd0, smp_if.sample_ready}, 1);
    push_frame('0, '0);
    n = 0;
    while (ur_count == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("underrun_seen", ur_count, 1);
    chk("underrun_cycle", ur_cyc, c + 128);
    chk("first_sck_rise", first_rise, c + CD);
    enable = 1'b0;
    wait_idle("starve");
    chk("starve_underrun_count", ur_count, 1);
    idle_outputs("starve");

    // Back-to-back random pairs over four frames.
    rise_cnt = 0;
    ur0 = ur_count;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      l = W'($urandom);
      r = W'($urandom);
      send_pair(l, r, c);
    end
    wait_ready("b2b");
    enable = 1'b0;
    wait_idle("b2b");
    chk("b2b_rises", rise_cnt, 128);
    chk("b2b_continuous_sck", last_rise - first_rise, 127 * 2 * CD);
    chk("b2b_underrun", ur_count, ur0);
    idle_outputs("b2b");

    // Handshake lands exactly in the load cycle with holding empty.
    rise_cnt = 0;
    ur0 = ur_count;
    enable = 1'b1;
    send_pair(W'($urandom), W'($urandom), c);
    while (cyc < c + 127) @(negedge clk);
    l = W'($urandom);
    r = W'($urandom);
    smp_if.sample_left  = l;
    smp_if.sample_right = r;
    smp_if.sample_valid = 1'b1;
    chk("bypass_ready_before", {31'd0, smp_if.sample_ready}, 1);
    push_frame(l, r);
    @(negedge clk);
    smp_if.sample_valid = 1'b0;
    chk("bypass_sd_msb", {31'd0, sd}, {31'd0, l[W-1]});
    chk("bypass_ready_after", {31'd0, smp_if.sample_ready}, 1);
    enable = 1'b0;
    wait_idle("bypass");
    chk("bypass_rises", rise_cnt, 64);
    chk("bypass_underrun", ur_count, ur0);
    idle_outputs("bypass");

    // enable dropped at slot 5: frame still completes.
    rise_cnt = 0;
    enable = 1'b1;
    send_pair(W'($urandom), W'($urandom), c);
    n = 0;
    while (rise_cnt < 6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    wait_idle("stop");
    chk("stop_rises", rise_cnt, 32);
    idle_outputs("stop");
    repeat (20) @(negedge clk);
    chk("stop_no_extra_rises", rise_cnt, 32);

    // Asynchronous reset at slot 20 with a pair pending in holding.
    rise_cnt = 0;
    enable = 1'b1;
    send_pair(W'($urandom), W'($urandom), c);
    send_pair(W'($urandom), W'($urandom), c);
    chk("pending_ready_low", {31'd0, smp_if.sample_ready}, 0);
    n = 0;
    while (rise_cnt < 21 && n < 200) begin
      @(negedge clk);
      n++;
    end
    #3;
    n_rst = 1'b0;
    #1;
    chk("arst_sck", {31'd0, sck}, 0);
    chk("arst_ws", {31'd0, ws}, 0);
    chk("arst_sd", {31'd0, sd}, 0);
    chk("arst_underrun", {31'd0, underrun}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_ready", {31'd0, smp_if.sample_ready}, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {31'd0, busy}, 0);
    rise_cnt = 0;
    slot_idx = 0;
    send_pair(W'($urandom), W'($urandom), c);
    enable = 1'b0;
    wait_idle("post_rst");
    chk("post_rst_rises", rise_cnt, 32);
    idle_outputs("post_rst");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
